serial_chan_arbiter: RTL and testbench
======================================

# serial_chan_arbiter

Multiplexes NUM_CLIENTS independent 32-bit word streams onto the single bramfeeder message channel of the serial physical device, and demultiplexes the return direction. On transmit it arbitrates round-robin between client bursts and prefixes each burst with a header word. On receive it parses headers and steers the payload to the addressed client. It sits between the serial device's bramfeeder put/get pins and the platform's virtual-channel clients.

## Interface
- NUM_CLIENTS, 4: number of clients, 2..16.
- MAX_BURST, 16: largest accepted burst length in words, ≤255.
- sys_clk_pin  in  1  single clock for all logic.
- sys_rst_pin  in  1  reset; synchronous, active-high.
- tx_data  in  32*NUM_CLIENTS  per-client payload word, client i at [32i+31:32i].
- tx_len  in  8*NUM_CLIENTS  burst length; sampled only at grant.
- tx_valid  in  NUM_CLIENTS  client has a word (burst) pending.
- tx_ready  out  NUM_CLIENTS  word accepted this cycle when valid&ready.
- rx_data  out  32  payload word, shared by all clients.
- rx_valid  out  NUM_CLIENTS  one-hot; word available for client i.
- rx_ready  in  NUM_CLIENTS  client i accepts word.
- ppc_put_data  out  32  to bramfeeder ppcMessageInput_put.
- ppc_put_en  out  1  EN_ppcMessageInput_put.
- ppc_put_rdy  in  1  RDY_ppcMessageInput_put.
- ppc_get_data  in  32  from bramfeeder ppcMessageOutput_get.
- ppc_get_en  out  1  EN_ppcMessageOutput_get.
- ppc_get_rdy  in  1  RDY_ppcMessageOutput_get.
- rx_err_count  out  16  saturating count of rejected headers.

## Operation
- Header word: [31:24]=8'hA5 magic, [23:16]=channel, [15:8]=0, [7:0]=length.
- Transfer on either bramfeeder port occurs when en&rdy; en is never asserted without rdy.
- TX FSM TX_IDLE→TX_HDR→TX_DATA→TX_IDLE.
- TX_IDLE: if any tx_valid, grant first valid client at or after rr_ptr; latch grant and len = min(tx_len, MAX_BURST); go TX_HDR.
- TX_HDR: ppc_put_data=header, ppc_put_en=ppc_put_rdy; on transfer go TX_DATA, or TX_IDLE if len==0.
- TX_DATA: ppc_put_data=tx_data[g]; ppc_put_en=ppc_put_rdy&tx_valid[g]; tx_ready[g]=ppc_put_rdy; other tx_ready 0. Decrement count per transfer; after last word go TX_IDLE, rr_ptr=(g+1) mod NUM_CLIENTS.
- Granted client dropping tx_valid mid-burst stalls the burst; no abort.
- RX FSM RX_HDR→RX_DATA|RX_DRAIN→RX_HDR.
- RX_HDR: ppc_get_en=ppc_get_rdy; on transfer latch chan,len. len==0 stays RX_HDR; chan≥NUM_CLIENTS goes RX_DRAIN; else RX_DATA.
- RX_DATA: rx_data=ppc_get_data (combinational); rx_valid[chan]=ppc_get_rdy; ppc_get_en=ppc_get_rdy&rx_ready[chan]; count down; after last go RX_HDR.
- RX_DRAIN: ppc_get_en=ppc_get_rdy, words discarded, rx_err_count+1 on entry; after len words go RX_HDR.
- TX and RX are fully independent and may transfer in the same cycle.

## Timing
- Reset (sys_rst_pin high at a clock edge): TX_IDLE, RX_HDR, rr_ptr=0, counts 0, rx_err_count=0; all en, tx_ready, rx_valid 0. Mid-burst reset abandons the burst; no header completion.
- Grant latency: 1 cycle from tx_valid in TX_IDLE to header offered.
- Burst of L words with rdy held high: L+1 cycles on the put port, plus 1 idle cycle before next grant.
- RX: zero-cycle pass-through from ppc_get_rdy/data to rx_valid/rx_data.
- rx_err_count saturates at 16'hFFFF.

## Configuration
- SERIAL_CHAN_ARB_MAGIC_CHECK_EN defined: RX_HDR rejects a header whose [31:24]≠8'hA5 as a single word (stays RX_HDR, rx_err_count+1, no drain).
- Undefined: magic byte ignored; only out-of-range channel is rejected via RX_DRAIN.

## Structure
- Package serial_chan_arb_pkg: HDR_MAGIC, header field bit positions, tx_state_t and rx_state_t enums.
- Sub-module serial_chan_arb_rr_pick: combinational round-robin picker (request vector, pointer → one-hot grant, any).

## Test plan
- Client 2 sends len 3 (words 1,2,3), rdy high → put stream A5020003,1,2,3; tx_ready[2] high 3 cycles.
- Clients 0 and 1 both valid, len 1 each, rr_ptr=0 → client 0 burst then client 1 burst; next grant from client 2.
- ppc_put_rdy toggled every cycle during burst → no word lost or duplicated; ppc_put_en never high while rdy low.
- Get stream A5010002,AA,BB with rx_ready[1] low 2 cycles → rx_valid[1] held, AA then BB delivered, no get_en while stalled.
- Get header A5070002 with NUM_CLIENTS=4 → 2 words drained, rx_err_count=1, no rx_valid.
- Macro defined: header 12000001 → dropped, rx_err_count=1, following word parsed as header.

Source files
------------

// File: rtl/serial_chan_arb_pkg.sv
// serial_chan_arb_pkg: shared definitions for the serial channel arbiter.
//   HDR_MAGIC          magic byte carried in header bits [31:24]
//   HDR_*_LSB          bit positions of the header fields (each 8 bits wide)
//   tx_state_t         transmit FSM states
//   rx_state_t         receive FSM states
//   make_hdr/sat_inc16 header builder and saturating counter step
package serial_chan_arb_pkg;

  localparam logic [7:0] HDR_MAGIC     = 8'hA5;
  localparam int         HDR_MAGIC_LSB = 24;
  localparam int         HDR_CHAN_LSB  = 16;
  localparam int         HDR_LEN_LSB   = 0;

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_DATA} tx_state_t;
  typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_DRAIN} rx_state_t;

  // Header layout: magic | channel | 8'h00 | length.
  function automatic logic [31:0] make_hdr(input logic [7:0] chan, input logic [7:0] len);
    return {HDR_MAGIC, chan, 8'h00, len};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/serial_chan_arb_if.sv
// serial_chan_arb_if: client streams plus bramfeeder put/get pins.
//   tx_data/tx_len/tx_valid/tx_ready  per-client transmit bursts (client i at index i)
//   rx_data/rx_valid/rx_ready         shared receive word, one-hot per-client valid
//   ppc_put_*                         bramfeeder ppcMessageInput_put
//   ppc_get_*                         bramfeeder ppcMessageOutput_get
// master = arbiter view, slave = clients + serial device view.
interface serial_chan_arb_if
  import serial_chan_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4
);
  logic [NUM_CLIENTS-1:0][31:0] tx_data;
  logic [NUM_CLIENTS-1:0][7:0]  tx_len;
  logic [NUM_CLIENTS-1:0]       tx_valid;
  logic [NUM_CLIENTS-1:0]       tx_ready;
  logic [31:0]                  rx_data;
  logic [NUM_CLIENTS-1:0]       rx_valid;
  logic [NUM_CLIENTS-1:0]       rx_ready;
  logic [31:0]                  ppc_put_data;
  logic                         ppc_put_en;
  logic                         ppc_put_rdy;
  logic [31:0]                  ppc_get_data;
  logic                         ppc_get_en;
  logic                         ppc_get_rdy;

  modport master (
    input  tx_data, tx_len, tx_valid, rx_ready, ppc_put_rdy, ppc_get_data, ppc_get_rdy,
    output tx_ready, rx_data, rx_valid, ppc_put_data, ppc_put_en, ppc_get_en
  );

  modport slave (
    output tx_data, tx_len, tx_valid, rx_ready, ppc_put_rdy, ppc_get_data, ppc_get_rdy,
    input  tx_ready, rx_data, rx_valid, ppc_put_data, ppc_put_en, ppc_get_en
  );
endinterface

// File: rtl/serial_chan_arb_rr_pick.sv
// serial_chan_arb_rr_pick: combinational round-robin picker.
//   req_i  request vector
//   ptr_i  highest-priority index this round
//   gnt_o  one-hot grant: first requester at or after ptr_i (wrapping)
//   any_o  at least one request present
module serial_chan_arb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic                 any_o
);
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[(int'(ptr_i) + i) % N]) begin
        any_o                       = 1'b1;
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/serial_chan_arbiter.sv
// serial_chan_arbiter: muxes NUM_CLIENTS word streams onto the bramfeeder
// put port (round-robin, one header word per burst) and steers headed
// packets from the get port back to the addressed client.
//   sys_clk_pin   clock
//   sys_rst_pin   synchronous active-high reset
//   bus           serial_chan_arb_if.master (client + bramfeeder pins)
//   rx_err_count  saturating count of rejected headers
// Optional build macro SERIAL_CHAN_ARB_MAGIC_CHECK_EN: headers with a bad
// magic byte are dropped as a single word and counted as errors.
module serial_chan_arbiter
  import serial_chan_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int MAX_BURST   = 16
) (
  input  logic                    sys_clk_pin,
  input  logic                    sys_rst_pin,
  serial_chan_arb_if.master       bus,
  output logic [15:0]             rx_err_count
);
  localparam int         CW   = $clog2(NUM_CLIENTS);
  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  // ---------------- transmit ----------------
  tx_state_t              tx_state_q;
  logic [CW-1:0]          gnt_q, rr_ptr_q, rr_next;
  logic [7:0]             tx_cnt_q;
  logic [NUM_CLIENTS-1:0] pick_gnt;
  logic                   pick_any;
  logic [CW-1:0]          pick_idx;
  logic [7:0]             pick_len;

  serial_chan_arb_rr_pick #(.N(NUM_CLIENTS)) u_pick (
    .req_i (bus.tx_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (pick_gnt[i]) pick_idx = CW'(i);
    pick_len = (bus.tx_len[pick_idx] > MAXB) ? MAXB : bus.tx_len[pick_idx];
  end

  assign rr_next = (gnt_q == CW'(NUM_CLIENTS - 1)) ? '0 : gnt_q + CW'(1);

  always_comb begin
    bus.ppc_put_data = '0;
    bus.ppc_put_en   = 1'b0;
    bus.tx_ready     = '0;
    case (tx_state_q)
      TX_HDR: begin
        bus.ppc_put_data = make_hdr(8'(gnt_q), tx_cnt_q);
        bus.ppc_put_en   = bus.ppc_put_rdy;
      end
      TX_DATA: begin
        bus.ppc_put_data    = bus.tx_data[gnt_q];
        bus.ppc_put_en      = bus.ppc_put_rdy & bus.tx_valid[gnt_q];
        bus.tx_ready[gnt_q] = bus.ppc_put_rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk_pin) begin
    if (sys_rst_pin) begin
      tx_state_q <= TX_IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (pick_any) begin
          gnt_q      <= pick_idx;
          tx_cnt_q   <= pick_len;
          tx_state_q <= TX_HDR;
        end
        TX_HDR: if (bus.ppc_put_en) begin
          // An empty burst still advances the pointer so a client
          // parked on len 0 cannot starve the others.
          if (tx_cnt_q == 8'd0) begin
            tx_state_q <= TX_IDLE;
            rr_ptr_q   <= rr_next;
          end else begin
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: if (bus.ppc_put_en) begin
          tx_cnt_q <= tx_cnt_q - 8'd1;
          if (tx_cnt_q == 8'd1) begin
            tx_state_q <= TX_IDLE;
            rr_ptr_q   <= rr_next;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receive ----------------
  rx_state_t     rx_state_q;
  logic [CW-1:0] rx_chan_q;
  logic [7:0]    rx_cnt_q;
  logic [15:0]   err_q;
  logic [7:0]    hdr_chan, hdr_len;
  logic          magic_ok;

  assign hdr_chan = bus.ppc_get_data[HDR_CHAN_LSB +: 8];
  assign hdr_len  = bus.ppc_get_data[HDR_LEN_LSB +: 8];
`ifdef SERIAL_CHAN_ARB_MAGIC_CHECK_EN
  assign magic_ok = (bus.ppc_get_data[HDR_MAGIC_LSB +: 8] == HDR_MAGIC);
`else
  assign magic_ok = 1'b1;
`endif

  assign bus.rx_data  = bus.ppc_get_data;
  assign rx_err_count = err_q;

  always_comb begin
    bus.rx_valid   = '0;
    bus.ppc_get_en = 1'b0;
    case (rx_state_q)
      RX_HDR:   bus.ppc_get_en = bus.ppc_get_rdy;
      RX_DATA: begin
        bus.rx_valid[rx_chan_q] = bus.ppc_get_rdy;
        bus.ppc_get_en          = bus.ppc_get_rdy & bus.rx_ready[rx_chan_q];
      end
      RX_DRAIN: bus.ppc_get_en = bus.ppc_get_rdy;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk_pin) begin
    if (sys_rst_pin) begin
      rx_state_q <= RX_HDR;
      rx_chan_q  <= '0;
      rx_cnt_q   <= '0;
      err_q      <= '0;
    end else begin
      case (rx_state_q)
        RX_HDR: if (bus.ppc_get_en) begin
          rx_cnt_q <= hdr_len;
          if (!magic_ok) begin
            err_q <= sat_inc16(err_q);
          end else if (hdr_len == 8'd0) begin
            rx_state_q <= RX_HDR;
          end else if (hdr_chan >= 8'(NUM_CLIENTS)) begin
            err_q      <= sat_inc16(err_q);
            rx_state_q <= RX_DRAIN;
          end else begin
            rx_chan_q  <= CW'(hdr_chan);
            rx_state_q <= RX_DATA;
          end
        end
        RX_DATA, RX_DRAIN: if (bus.ppc_get_en) begin
          rx_cnt_q <= rx_cnt_q - 8'd1;
          if (rx_cnt_q == 8'd1) rx_state_q <= RX_HDR;
        end
        default: rx_state_q <= RX_HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_chan_arbiter.sv
// tb_serial_chan_arbiter: randomized self-checking bench. TX is predicted by
// a burst-level round-robin model, RX by a word-stream header parser.
module tb_serial_chan_arbiter;
  localparam int N  = 4;
  localparam int MB = 16;
`ifdef SERIAL_CHAN_ARB_MAGIC_CHECK_EN
  localparam bit MCHK = 1'b1;
`else
  localparam bit MCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_cnt;
  always #5 clk = ~clk;

  serial_chan_arb_if #(.NUM_CLIENTS(N)) bus();

  serial_chan_arbiter #(.NUM_CLIENTS(N), .MAX_BURST(MB)) dut (
    .sys_clk_pin  (clk),
    .sys_rst_pin  (rst),
    .bus          (bus),
    .rx_err_count (err_cnt)
  );

  int errors = 0, checks = 0;
  int mptr, mcnt;

  // TX client drivers and model state
  int unsigned adv_q[N][$];
  logic [31:0] wq[N][$];
  int          rem[N], full[N], cur_adv[N], rdy_cnt[N];
  logic [31:0] exp_q[$], obs_q[$];
  int          obs_cyc[$];

  // RX stream and model state
  logic [31:0] gq[$];
  logic [35:0] exp_rx[$], obs_rx[$];
  int          stall_cnt;

  task automatic push_burst(input int c, input int adv, input logic [31:0] base);
    int n;
    n = (adv > MB) ? MB : adv;
    adv_q[c].push_back(adv);
    for (int k = 0; k < n; k++) wq[c].push_back(base + k);
  endtask

  task automatic drive_clients(input int mode);
    for (int c = 0; c < N; c++) begin
      if (rem[c] == 0 && adv_q[c].size() > 0) begin
        cur_adv[c] = adv_q[c].pop_front();
        rem[c]     = (cur_adv[c] > MB) ? MB : cur_adv[c];
        full[c]    = rem[c];
      end
      bus.tx_valid[c] = (rem[c] > 0);
      if (mode == 2 && rem[c] > 0 && rem[c] < full[c] && $urandom_range(0, 2) == 0)
        bus.tx_valid[c] = 1'b0;
      bus.tx_len[c]  = 8'(cur_adv[c]);
      bus.tx_data[c] = (rem[c] > 0) ? wq[c][0] : 32'h0;
    end
  endtask

  // Burst-level model: every queued burst is pending from the start, so the
  // put stream is fixed by round-robin order over clients with bursts left.
  task automatic run_tx(input int mode, input int budget);
    logic [N-1:0] acc;
    int viol, cyc, c, a, n;
    int ai[N], wi[N];
    bit idle;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    for (int i = 0; i < N; i++) begin ai[i] = 0; wi[i] = 0; rdy_cnt[i] = 0; end
    forever begin
      c = -1;
      for (int o = 0; o < N; o++)
        if (c < 0 && ai[(mptr + o) % N] < adv_q[(mptr + o) % N].size()) c = (mptr + o) % N;
      if (c < 0) break;
      a = adv_q[c][ai[c]]; ai[c]++;
      n = (a > MB) ? MB : a;
      exp_q.push_back({8'hA5, 8'(c), 8'h00, 8'(n)});
      for (int k = 0; k < n; k++) begin exp_q.push_back(wq[c][wi[c]]); wi[c]++; end
      mptr = (c + 1) % N;
    end
    viol = 0; cyc = 0;
    @(posedge clk); #1;
    bus.ppc_put_rdy = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_clients(mode);
    while (cyc < budget) begin
      idle = 1'b1;
      for (int i = 0; i < N; i++) if (rem[i] != 0 || adv_q[i].size() != 0) idle = 1'b0;
      if (idle && obs_q.size() >= exp_q.size()) break;
      @(negedge clk);
      if (bus.ppc_put_en && !bus.ppc_put_rdy) viol++;
      if ($countones(bus.tx_ready) > 1) viol++;
      if (bus.ppc_put_en) begin obs_q.push_back(bus.ppc_put_data); obs_cyc.push_back(cyc); end
      for (int i = 0; i < N; i++) if (bus.tx_ready[i]) rdy_cnt[i]++;
      acc = bus.tx_valid & bus.tx_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (acc[i]) begin void'(wq[i].pop_front()); rem[i]--; end
      case (mode)
        0:       bus.ppc_put_rdy = 1'b1;
        1:       bus.ppc_put_rdy = ~bus.ppc_put_rdy;
        default: bus.ppc_put_rdy = 1'($urandom_range(0, 1));
      endcase
      drive_clients(mode);
      cyc++;
    end
    bus.tx_valid = '0; bus.ppc_put_rdy = 1'b0;
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL tx_len: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL tx_word[%0d]: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL tx_protocol: got %0d violations want 0", viol); end
  endtask

  // Stream-level parser: header -> deliver / drain / drop.
  task automatic rx_model();
    int i, ch, ln;
    logic [31:0] h;
    i = 0;
    while (i < gq.size()) begin
      h = gq[i]; i++;
      if (MCHK && h[31:24] != 8'hA5) begin mcnt++; continue; end
      ch = int'(h[23:16]); ln = int'(h[7:0]);
      if (ln == 0) continue;
      if (ch >= N) mcnt++;
      else for (int k = 0; k < ln; k++) exp_rx.push_back({4'(ch), gq[i + k]});
      i += ln;
    end
  endtask

  task automatic run_rx(input int rmode, input int sch, input int lo, input int hi, input int budget);
    int viol, cyc;
    bit pop;
    exp_rx.delete(); obs_rx.delete();
    rx_model();
    viol = 0; cyc = 0; pop = 1'b0; stall_cnt = 0;
    while (cyc < budget) begin
      @(posedge clk); #1;
      if (pop) void'(gq.pop_front());
      bus.ppc_get_rdy  = (gq.size() > 0) && (rmode == 0 || $urandom_range(0, 3) != 0);
      bus.ppc_get_data = (gq.size() > 0) ? gq[0] : $urandom;
      if (rmode == 0) begin
        bus.rx_ready = '1;
        if (cyc >= lo && cyc <= hi) bus.rx_ready[sch] = 1'b0;
      end else bus.rx_ready = N'($urandom);
      if (gq.size() == 0) break;
      @(negedge clk);
      if (bus.ppc_get_en && !bus.ppc_get_rdy) viol++;
      if ($countones(bus.rx_valid) > 1) viol++;
      if (bus.rx_valid != '0 && !bus.ppc_get_rdy) viol++;
      for (int c = 0; c < N; c++) begin
        if (bus.rx_valid[c] && !bus.rx_ready[c]) begin
          if (c == sch) stall_cnt++;
          if (bus.ppc_get_en) viol++;
        end
        if (bus.rx_valid[c] && bus.rx_ready[c]) begin
          obs_rx.push_back({4'(c), bus.rx_data});
          if (!bus.ppc_get_en) viol++;
        end
      end
      pop = bus.ppc_get_en;
      cyc++;
    end
    bus.ppc_get_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_rx.size() !== exp_rx.size()) begin
      errors++; $display("FAIL rx_len: got %0d words want %0d", obs_rx.size(), exp_rx.size());
    end
    for (int k = 0; k < obs_rx.size() && k < exp_rx.size(); k++) begin
      checks++;
      if (obs_rx[k] !== exp_rx[k]) begin
        errors++; $display("FAIL rx_word[%0d]: got %h want %h", k, obs_rx[k], exp_rx[k]);
      end
    end
    checks++;
    if (err_cnt !== 16'(mcnt)) begin errors++; $display("FAIL rx_err_count: got %0d want %0d", err_cnt, mcnt); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL rx_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic clear_tx();
    for (int c = 0; c < N; c++) begin
      adv_q[c].delete(); wq[c].delete(); rem[c] = 0; full[c] = 0; cur_adv[c] = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tx_valid = '1; bus.tx_len = '1; bus.tx_data = '0;
    bus.ppc_put_rdy = 1'b1; bus.ppc_get_rdy = 1'b0; bus.ppc_get_data = '0; bus.rx_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ppc_put_en !== 1'b0) begin errors++; $display("FAIL rst_put_en: got %b want 0", bus.ppc_put_en); end
    checks++; if (bus.tx_ready !== '0) begin errors++; $display("FAIL rst_tx_ready: got %b want 0", bus.tx_ready); end
    checks++; if (bus.rx_valid !== '0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", bus.rx_valid); end
    checks++; if (bus.ppc_get_en !== 1'b0) begin errors++; $display("FAIL rst_get_en: got %b want 0", bus.ppc_get_en); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
    @(posedge clk); #1;
    bus.tx_valid = '0; bus.ppc_put_rdy = 1'b0; rst = 1'b0;
    mptr = 0; mcnt = 0; clear_tx();
  endtask

  task automatic test_tx_single();
    logic [31:0] first;
    push_burst(2, 3, 32'd1);
    run_tx(0, 50);
    first = (obs_q.size() > 0) ? obs_q[0] : 32'hx;
    checks++; if (first !== 32'hA5020003) begin errors++; $display("FAIL single_hdr: got %h want a5020003", first); end
    checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] !== 1) begin
      errors++; $display("FAIL grant_latency: got %0d want 1", (obs_cyc.size() > 0) ? obs_cyc[0] : -1);
    end
    checks++; if (rdy_cnt[2] !== 3) begin errors++; $display("FAIL single_ready: got %0d cycles want 3", rdy_cnt[2]); end
  endtask

  task automatic test_tx_rr();
    logic [31:0] first;
    push_burst(0, 1, 32'h10);
    push_burst(1, 1, 32'h20);
    run_tx(0, 50);
    checks++;
    if (obs_cyc.size() < 3 || obs_cyc[2] !== 4) begin
      errors++; $display("FAIL rr_gap: got %0d want 4", (obs_cyc.size() > 2) ? obs_cyc[2] : -1);
    end
    push_burst(3, 2, 32'h30);
    push_burst(2, 2, 32'h40);
    run_tx(0, 50);
    first = (obs_q.size() > 0) ? obs_q[0] : 32'hx;
    checks++; if (first[23:16] !== 8'd2) begin errors++; $display("FAIL rr_next: got %0d want 2", first[23:16]); end
  endtask

  task automatic test_tx_toggle();
    push_burst(1, 5, 32'h100);
    push_burst(3, 4, 32'h200);
    run_tx(1, 100);
  endtask

  task automatic test_tx_clamp();
    logic [31:0] first;
    push_burst(3, 20, 32'h300);
    run_tx(0, 60);
    first = (obs_q.size() > 0) ? obs_q[0] : 32'hx;
    checks++; if (first !== 32'hA5030010) begin errors++; $display("FAIL clamp_hdr: got %h want a5030010", first); end
  endtask

  task automatic test_tx_random();
    for (int k = 0; k < 12; k++)
      push_burst($urandom_range(0, N - 1), $urandom_range(1, MB), $urandom);
    run_tx(2, 3000);
  endtask

  task automatic test_rx_stall();
    gq = '{32'hA5010002, 32'hAA, 32'hBB};
    run_rx(0, 1, 1, 2, 50);
    checks++; if (stall_cnt !== 2) begin errors++; $display("FAIL rx_stall: got %0d cycles want 2", stall_cnt); end
  endtask

  task automatic test_rx_drain();
    gq = '{32'hA5070002, 32'h11111111, 32'h22222222, 32'hA5000001, 32'h77};
    run_rx(0, 0, -1, -2, 50);
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL drain_err: got %0d want 1", err_cnt); end
  endtask

  task automatic test_rx_magic();
    gq = '{32'h12000001, 32'hA5010001, 32'hA5000000};
    run_rx(0, 0, -1, -2, 50);
  endtask

  task automatic test_rx_random();
    int ch, ln;
    gq.delete();
    for (int p = 0; p < 10; p++) begin
      ch = $urandom_range(0, N + 1);
      ln = $urandom_range(0, 4);
      gq.push_back({8'hA5, 8'(ch), 8'h00, 8'(ln)});
      for (int k = 0; k < ln; k++) gq.push_back($urandom);
    end
    run_rx(1, 0, -1, -2, 2000);
  endtask

  task automatic test_mid_reset();
    push_burst(1, 1, 32'h500);
    run_tx(0, 50);
    @(posedge clk); #1;
    bus.tx_valid = 4'b0010; bus.tx_len[1] = 8'd8; bus.tx_data[1] = 32'h600; bus.ppc_put_rdy = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1; bus.tx_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.ppc_put_en !== 1'b0) begin errors++; $display("FAIL midrst_put_en: got %b want 0", bus.ppc_put_en); end
    checks++; if (bus.tx_ready !== '0) begin errors++; $display("FAIL midrst_tx_ready: got %b want 0", bus.tx_ready); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL midrst_err: got %0d want 0", err_cnt); end
    @(posedge clk); #1;
    rst = 1'b0; bus.ppc_put_rdy = 1'b0;
    mptr = 0; mcnt = 0; clear_tx();
    push_burst(3, 1, 32'h700);
    push_burst(0, 1, 32'h800);
    run_tx(0, 50);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_single();
    test_tx_rr();
    test_tx_toggle();
    test_tx_clamp();
    test_tx_random();
    test_rx_stall();
    test_rx_drain();
    test_rx_magic();
    test_rx_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
